// File: rtl/avm_ram_fill_check_if.sv
// Avalon-MM word-addressed bus between the fill/check master and the on-chip RAM slave.
interface avm_ram_fill_check_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic                avm_read;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avm_ram_fill_check.sv
// RAM fill-then-verify master: writes seed/seed+i over a word range, reads it back,
// and reports error count and the first failing address.
module avm_ram_fill_check #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 incr,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W:0]      err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  avm_ram_fill_check_if.master avm
);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, FIN} state_t;

  state_t            state, state_n;
  logic              armed;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [ADDR_W:0]   len_q, len_n, idx, idx_n, err_n;
  logic [DATA_W-1:0] seed_q, seed_n;
  logic              incr_q, incr_n, pass_n;
  logic [ADDR_W-1:0] ferr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_pat;
  logic              last, req;

  // Address wraps naturally through the ADDR_W-bit add.
  assign cur_addr = base_q + idx[ADDR_W-1:0];
  assign cur_pat  = incr_q ? seed_q + DATA_W'(idx) : seed_q;
  assign last     = (idx == len_q - 1'b1);
  assign req      = (state == WR) || (state == RD);

  assign avm.avm_address    = req ? cur_addr : '0;
  assign avm.avm_byteenable = {(DATA_W/8){req}};
  assign avm.avm_chipselect = req;
  assign avm.avm_write      = (state == WR);
  assign avm.avm_read       = (state == RD);
  assign avm.avm_writedata  = (state == WR) ? cur_pat : '0;
  assign busy               = (state == WR) || (state == RD) || (state == RWAIT);
  assign done               = (state == FIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      seed_q         <= '0;
      incr_q         <= 1'b0;
      idx            <= '0;
      cnt            <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      armed          <= 1'b1;
      base_q         <= base_n;
      len_q          <= len_n;
      seed_q         <= seed_n;
      incr_q         <= incr_n;
      idx            <= idx_n;
      cnt            <= cnt_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    base_n  = base_q;
    len_n   = len_q;
    seed_n  = seed_q;
    incr_n  = incr_q;
    idx_n   = idx;
    cnt_n   = cnt;
    pass_n  = pass;
    err_n   = err_count;
    ferr_n  = first_err_addr;
    unique case (state)
      IDLE: begin
        // armed blocks a start that coincides with reset release
        if (start && armed) begin
          base_n  = base_addr;
          len_n   = length;
          seed_n  = seed;
          incr_n  = incr;
          idx_n   = '0;
          err_n   = '0;
          ferr_n  = '0;
          pass_n  = (length == '0);
          state_n = (length == '0) ? FIN : WR;
        end
      end
      WR: begin
        if (!avm.avm_waitrequest) begin
          if (last) begin
            idx_n   = '0;
            state_n = RD;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      RD: begin
        if (!avm.avm_waitrequest) begin
          cnt_n   = CNT_W'(READ_LATENCY);
          state_n = RWAIT;
        end
      end
      RWAIT: begin
        if (cnt == CNT_W'(1)) begin
          if (avm.avm_readdata != cur_pat) begin
            err_n = err_count + 1'b1;
            if (err_count == '0) ferr_n = cur_addr;
          end
          if (last) begin
            pass_n  = (err_n == '0);
            state_n = FIN;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = RD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/avm_ram_fill_check.md
Name: avm_ram_fill_check

Overview:
- Avalon-MM master that drives the 32-bit x 4096-word on-chip RAM slave from the other end of its port.
- On a start command it writes a generated data pattern over a word range, then reads the range back and compares against the same pattern.
- Reports pass/fail, error count and first failing address.
- Used for RAM bring-up and self-test ahead of processor boot, and as a bulk initializer.

Parameters:
- ADDR_W, 12, word-address width of the slave (depth 2^ADDR_W).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed slave read latency in clocks (>=1; slave has no readdatavalid).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only while busy=0
- incr  in  1  pattern mode: 1 = seed+i, 0 = constant seed
- base_addr  in  ADDR_W  first word address
- length  in  ADDR_W+1  word count, 0..4096
- seed  in  DATA_W  pattern seed
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  1 when err_count==0; valid from done until next start
- err_count  out  ADDR_W+1  number of mismatching words
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
- avm_address  out  ADDR_W  word address
- avm_byteenable  out  DATA_W/8  constant all-ones while chipselect=1, else 0
- avm_chipselect  out  1  asserted with read or write
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Async reset (reset_n=0): state IDLE; busy, done, pass, err_count, first_err_addr, all avm_* outputs = 0.
- States: IDLE, WR, RD, RWAIT, FIN.
- IDLE: on start=1, latch base_addr, length, seed and incr; clear err_count and first_err_addr; pass=0; busy=1 next cycle.
  - length==0 -> FIN.
  - Otherwise -> WR with index i=0.
- start while busy=1 is ignored. start and reset_n deassertion in the same cycle: start is ignored.
- Address for index i = (base_addr + i) mod 2^ADDR_W. Wraps 4095 -> 0; no error.
- Pattern for index i:
  - incr=1: seed + i, mod 2^DATA_W.
  - incr=0: seed.
- WR: avm_write=1, chipselect=1, address/writedata for index i. All held stable while avm_waitrequest=1.
  - On a clock with waitrequest=0 the write is accepted; i++.
  - On the last accept (i==length-1): i=0 -> RD. Writes are back-to-back with no idle cycle.
- RD: avm_read=1, chipselect=1, address for index i, held while waitrequest=1.
  - On accept: read deasserts next cycle -> RWAIT; latency counter loads READ_LATENCY.
- RWAIT: counter decrements each clock. Read data is sampled on the edge READ_LATENCY clocks after the accept edge and compared to the pattern for index i.
  - On mismatch: err_count++. If err_count was 0, first_err_addr is set to that address.
  - Then, if i==length-1 -> FIN, else i++ -> RD.
  - One outstanding read at a time; no pipelining.
- FIN: done=1 for exactly one cycle; busy=0 in the same cycle; pass=(err_count==0); -> IDLE.
- err_count, first_err_addr and pass hold until the next accepted start.
- Write and read are never asserted in the same cycle. Outside WR/RD all avm_* outputs = 0.
- Reset mid-operation aborts immediately; the RAM contents are left partial and there is no done pulse.
- Throughput with no waitrequest:
  - Writes: 1 word/clk.
  - Reads: 1 word per (1 + READ_LATENCY) clk.
  - Total cycles from start to done: 1 + L + L*(1+READ_LATENCY) + 1.

Test Plan:
- Bench RAM model with READ_LATENCY=1. Stimulus: base=0x010, length=4, seed=0xA5A50000, incr=1 -> writes 0xA5A50000..0xA5A50003 to addr 0x010..0x013; done after 1+4+8+1=14 clocks; pass=1, err_count=0.
- Wrap: base=0xFFE, length=4, incr=0, seed=0xDEADBEEF -> addresses 0xFFE, 0xFFF, 0x000, 0x001 all hold 0xDEADBEEF; pass=1.
- Fault injection: model forces addr 0x005 readdata to 0, run base=0, length=8, seed=1, incr=1 -> err_count=1, first_err_addr=0x005, pass=0.
- Random waitrequest (50%) on writes and reads, length=16 -> address/writedata stable while stalled; every word written exactly once; pass=1.
- length=0 -> no avm activity; done pulses 2 clocks after start; pass=1, err_count=0.
- Drop reset_n mid-WR at i=3 of 8 -> all outputs 0 asynchronously; no done. A start re-issued after reset completes normally. A start pulsed while busy has no effect.
